// File: rtl/memory_pkg.sv
// Shared types and constants for the data-memory responder.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 32;

    // True when the word address has any bit set above the array index range.
    function automatic logic addr_out_of_range(input logic [DMEM_ADDR_W-1:0] addr,
                                               input int depth_log2);
        return ((addr >> depth_log2) != 32'd0);
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Memory-stage to data-memory request/response bundle.
interface data_memory_responder_if;
    import memory_pkg::*;

    logic [DMEM_ADDR_W-1:0] Address;
    logic [DMEM_DATA_W-1:0] DataIn;
    logic                   MemoryRead;
    logic                   MemoryWrite;
    logic [DMEM_DATA_W-1:0] DataOut;
    logic                   Busy;
    logic                   Done;
    logic                   AddrError;

    // Memory stage side.
    modport master (
        output Address, DataIn, MemoryRead, MemoryWrite,
        input  DataOut, Busy, Done, AddrError
    );

    // Responder side.
    modport slave (
        input  Address, DataIn, MemoryRead, MemoryWrite,
        output DataOut, Busy, Done, AddrError
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM; storage is not reset, the read register is.
module dmem_array
    import memory_pkg::*;
#(
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic                   re_i,
    input  logic [DEPTH_LOG2-1:0]  addr_i,
    input  logic [DMEM_DATA_W-1:0] wdata_i,
    output logic [DMEM_DATA_W-1:0] rdata_o
);

    logic [DMEM_DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [DMEM_DATA_W-1:0] rdata_q;

    // Write port: contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: holds the last read word until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 16'h0000;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency data-memory responder: FSM, latency counter, request
// latches and error decode in front of a synchronous RAM.
module data_memory_responder
    import memory_pkg::*;
#(
    parameter int DEPTH_LOG2 = 11,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    data_memory_responder_if.slave  bus
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_t             state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic [DMEM_DATA_W-1:0]  data_q, data_d;
    logic                    is_rd_q, is_rd_d;
    logic                    err_q, err_d;

    logic                    req_s;
    logic                    busy_s;
    logic                    to_resp_s;
    logic                    we_s;
    logic                    re_s;
    logic [DMEM_DATA_W-1:0]  rdata_s;

    assign req_s = bus.MemoryRead | bus.MemoryWrite;

    // Next-state, latch loading and access strobes; the _d latches double
    // as the access operands so a single-cycle latency can use live inputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        is_rd_d   = is_rd_q;
        err_d     = err_q;
        busy_s    = 1'b0;
        to_resp_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    busy_s  = 1'b1;
                    addr_d  = bus.Address[DEPTH_LOG2-1:0];
                    data_d  = bus.DataIn;
                    is_rd_d = bus.MemoryRead;
                    err_d   = addr_out_of_range(bus.Address, DEPTH_LOG2) |
                              (bus.MemoryRead & bus.MemoryWrite);
                    cnt_d   = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d   = RESP;
                        to_resp_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                busy_s = 1'b1;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = RESP;
                    to_resp_s = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        we_s = to_resp_s & ~err_d & ~is_rd_d;
        re_s = to_resp_s & ~err_d & is_rd_d;
    end

    // FSM, counter and request latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 16'h0000;
            is_rd_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            is_rd_q <= is_rd_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_s),
        .re_i    (re_s),
        .addr_i  (addr_d),
        .wdata_i (data_d),
        .rdata_o (rdata_s)
    );

    assign bus.Busy      = busy_s;
    assign bus.Done      = (state_q == RESP);
    assign bus.AddrError = (state_q == RESP) & err_q;
    assign bus.DataOut   = rdata_s;

endmodule
